// File: rtl/iob_wishbone2iob_pipe.sv
// Pipelined Wishbone B4 slave to IOb master bridge: a request FIFO replayed one transaction at a time.
// Define WB2IOB_TIMEOUT_EN to add the IOb response timeout (wb_err_o); otherwise WAIT persists indefinitely.
module iob_wishbone2iob_pipe #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [ADDR_W-1:0]           wb_adr_i,
    input  logic [DATA_W/8-1:0]         wb_sel_i,
    input  logic                        wb_we_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic [DATA_W-1:0]           wb_dat_i,
    output logic                        wb_stall_o,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic [DATA_W-1:0]           wb_dat_o,
    output logic                        valid_o,
    output logic [ADDR_W-1:0]           address_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic [DATA_W/8-1:0]         wstrb_o,
    input  logic [DATA_W-1:0]           rdata_i,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic [1:0]                  dbg_state_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              aborted_q, aborted_d;
    logic              read_q, read_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    logic [ADDR_W-1:0] adr_mem_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] dat_mem_q  [FIFO_DEPTH];
    logic [STRB_W-1:0] strb_mem_q [FIFO_DEPTH];

    logic              push, pop, flush, busy, issue;
    logic              done, timeout, finish, suppress, cur_read;
    logic [ADDR_W-1:0] head_adr;
    logic [DATA_W-1:0] head_dat;
    logic [STRB_W-1:0] head_strb;

    // Handshakes: a Wishbone request transfers at a rising edge with wb_cyc_i & wb_stb_i & ~wb_stall_o.
    // valid_o is a one-cycle IOb request; ready_i is a one-cycle response honoured only in ISSUE or WAIT.
    assign head_adr  = adr_mem_q[rd_ptr_q];
    assign head_dat  = dat_mem_q[rd_ptr_q];
    assign head_strb = strb_mem_q[rd_ptr_q];

`ifdef WB2IOB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Fires on the WAIT cycle where the counter would reach its all-ones value.
    always_comb begin
        tmo_cnt_d = '0;
        timeout   = 1'b0;
        if (state_q == S_WAIT && !ready_i) begin
            if (tmo_cnt_q == TMO_LAST) begin
                timeout = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam logic [TIMEOUT_W-1:0] TMO_OFF = '0;

    assign timeout = |TMO_OFF;
`endif

    always_comb begin
        push     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
        issue    = (state_q == S_ISSUE);
        busy     = (state_q != S_IDLE);
        pop      = issue;
        flush    = ~wb_cyc_i;
        done     = busy & ready_i;
        finish   = done | timeout;
        cur_read = issue ? (head_strb == '0) : read_q;
        suppress = aborted_q | flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end

        // Next-state decisions use the post-push/pop level so a sustained burst issues every cycle.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (level_d != '0) state_d = S_ISSUE;
            S_ISSUE: begin
                if (ready_i) state_d = (level_d != '0) ? S_ISSUE : S_IDLE;
                else         state_d = S_WAIT;
            end
            S_WAIT:  if (finish) state_d = (level_d != '0) ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        read_d = issue ? (head_strb == '0) : read_q;

        aborted_d = aborted_q;
        if (finish) begin
            aborted_d = 1'b0;
        end else if (busy && flush) begin
            aborted_d = 1'b1;
        end

        ack_d = done & ~suppress;
        err_d = timeout & ~suppress;
        dat_d = (ack_d && cur_read) ? rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            aborted_q <= 1'b0;
            read_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            aborted_q <= aborted_d;
            read_q    <= read_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    // Storage needs no reset: entries are only visible while level is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            adr_mem_q[wr_ptr_q]  <= wb_adr_i;
            dat_mem_q[wr_ptr_q]  <= wb_dat_i;
            strb_mem_q[wr_ptr_q] <= wb_we_i ? wb_sel_i : '0;
        end
    end

    assign wb_stall_o  = (level_q == FULL_LVL);
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_dat_o    = dat_q;
    assign valid_o     = (state_q == S_ISSUE);
    assign address_o   = valid_o ? head_adr : '0;
    assign wdata_o     = valid_o ? head_dat : '0;
    assign wstrb_o     = valid_o ? head_strb : '0;
    assign level_o     = level_q;
    assign dbg_state_o = state_q;

endmodule
